// File: rtl/mem_pkg.sv
// Shared types and constants for the parametrised 1W/1R RAM with March BIST.
package mem_pkg;

    // BIST sequencer states, in the order a run visits them.
    typedef enum logic [2:0] {
        IDLE,
        W0,
        R0W1,
        R1W0,
        R0,
        DONE
    } bist_state_e;

    // Fill bits for the March patterns; replicate to the data width at the point of use.
    localparam logic MEM_PAT0 = 1'b0;
    localparam logic MEM_PAT1 = 1'b1;

    // Supported read latencies.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

endpackage

// File: rtl/mem_bist_ctrl.sv
// March BIST sequencer: W0, R0W1 (up), R1W0 (down), R0 (up). Issues array
// requests, compares read-back data and keeps a sticky fail flag plus the
// address of the first miscompare.
module mem_bist_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bist_start,
    input  logic [DATA_W-1:0] ram_q,
    output logic              bist_wr_en,
    output logic              bist_rd_en,
    output logic [ADDR_W-1:0] bist_addr,
    output logic [DATA_W-1:0] bist_wr_data,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_fail,
    output logic [ADDR_W-1:0] bist_fail_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    // Read data is checked RD_LAT cycles after the read is issued.
    localparam logic [1:0]        CMP_CNT   = 2'(RD_LAT);
    localparam logic [DATA_W-1:0] PAT0      = {DATA_W{MEM_PAT0}};
    localparam logic [DATA_W-1:0] PAT1      = {DATA_W{MEM_PAT1}};

    bist_state_e       state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [1:0]        cnt_reg, cnt_next;
    logic              fail_reg, fail_next;
    logic [ADDR_W-1:0] fail_addr_reg, fail_addr_next;
    logic              cmp_en;
    logic [DATA_W-1:0] cmp_exp;

    assign bist_addr      = addr_reg;
    assign bist_busy      = (state_reg != IDLE) && (state_reg != DONE);
    assign bist_done      = (state_reg == DONE);
    assign bist_fail      = fail_reg;
    assign bist_fail_addr = fail_addr_reg;

    // State, address/latency counters and fail capture registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            cnt_reg       <= '0;
            fail_reg      <= 1'b0;
            fail_addr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            cnt_reg       <= cnt_next;
            fail_reg      <= fail_next;
            fail_addr_reg <= fail_addr_next;
        end
    end

    // Next-state sequencing, array requests and read-back comparison.
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        cnt_next       = cnt_reg;
        fail_next      = fail_reg;
        fail_addr_next = fail_addr_reg;
        bist_wr_en     = 1'b0;
        bist_rd_en     = 1'b0;
        bist_wr_data   = PAT0;
        cmp_en         = 1'b0;
        cmp_exp        = PAT0;

        case (state_reg)
            IDLE, DONE: begin
                if (bist_start) begin
                    state_next     = W0;
                    addr_next      = '0;
                    cnt_next       = '0;
                    fail_next      = 1'b0;
                    fail_addr_next = '0;
                end
            end
            W0: begin
                bist_wr_en = 1'b1;
                if (addr_reg == LAST_ADDR) begin
                    state_next = R0W1;
                    addr_next  = '0;
                end else begin
                    addr_next = addr_reg + 1'b1;
                end
            end
            R0W1, R1W0, R0: begin
                bist_rd_en = (cnt_reg == 2'd0);
                cmp_exp    = (state_reg == R1W0) ? PAT1 : PAT0;
                if (cnt_reg == CMP_CNT) begin
                    // Compare and write-back share the last cycle of each address slot.
                    cmp_en       = 1'b1;
                    cnt_next     = '0;
                    bist_wr_en   = (state_reg != R0);
                    bist_wr_data = (state_reg == R0W1) ? PAT1 : PAT0;
                    case (state_reg)
                        R0W1: begin
                            if (addr_reg == LAST_ADDR) begin
                                state_next = R1W0;
                                addr_next  = LAST_ADDR;
                            end else begin
                                addr_next = addr_reg + 1'b1;
                            end
                        end
                        R1W0: begin
                            if (addr_reg == '0) begin
                                state_next = R0;
                                addr_next  = '0;
                            end else begin
                                addr_next = addr_reg - 1'b1;
                            end
                        end
                        default: begin
                            if (addr_reg == LAST_ADDR) begin
                                state_next = DONE;
                            end else begin
                                addr_next = addr_reg + 1'b1;
                            end
                        end
                    endcase
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (cmp_en && (ram_q != cmp_exp)) begin
            fail_next = 1'b1;
            if (!fail_reg) begin
                fail_addr_next = addr_reg;
            end
        end
    end

endmodule

// File: rtl/mem_ram_2p_bist.sv
// Parametrised 1W/1R synchronous RAM with RD_LAT-cycle read pipeline and an
// embedded March BIST engine that takes over the array while it runs.
module mem_ram_2p_bist
    import mem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_wr_addr,
    input  logic [DATA_W-1:0] mem_wr_data,
    input  logic              mem_rd_en,
    input  logic [ADDR_W-1:0] mem_rd_addr,
    output logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_rd_valid,
    input  logic              bist_start,
    output logic              bist_busy,
    output logic              bist_done,
    output logic              bist_fail,
    output logic [ADDR_W-1:0] bist_fail_addr
);

    // Out-of-range latencies collapse to the nearest supported value.
    localparam int              LAT     = (RD_LAT <= RD_LAT_MIN) ? RD_LAT_MIN : RD_LAT_MAX;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic              bist_wr_en, bist_rd_en;
    logic [ADDR_W-1:0] bist_addr;
    logic [DATA_W-1:0] bist_wr_data;
    logic              ram_wr_en, ram_rd_en;
    logic [ADDR_W-1:0] ram_wr_addr, ram_rd_addr;
    logic [DATA_W-1:0] ram_wr_data;
    logic              wr_in_range, rd_in_range;

    logic [DATA_W-1:0] mem_array [DEPTH];
    logic [DATA_W-1:0] ram_q_reg;
    logic [DATA_W-1:0] ram_q;
    logic              range_q_reg;
    logic              v0_reg;
    logic [DATA_W-1:0] last_data;
    logic              last_valid;
    logic [DATA_W-1:0] rd_data_reg;
    logic              rd_valid_reg;

    mem_bist_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .RD_LAT (LAT)
    ) u_bist (
        .clk            (clk),
        .rst            (rst),
        .bist_start     (bist_start),
        .ram_q          (ram_q),
        .bist_wr_en     (bist_wr_en),
        .bist_rd_en     (bist_rd_en),
        .bist_addr      (bist_addr),
        .bist_wr_data   (bist_wr_data),
        .bist_busy      (bist_busy),
        .bist_done      (bist_done),
        .bist_fail      (bist_fail),
        .bist_fail_addr (bist_fail_addr)
    );

    // Array port mux: BIST owns the array while busy, functional ports otherwise.
    always_comb begin
        ram_wr_en   = bist_busy ? bist_wr_en   : mem_wr_en;
        ram_wr_addr = bist_busy ? bist_addr    : mem_wr_addr;
        ram_wr_data = bist_busy ? bist_wr_data : mem_wr_data;
        ram_rd_en   = bist_busy ? bist_rd_en   : mem_rd_en;
        ram_rd_addr = bist_busy ? bist_addr    : mem_rd_addr;
        wr_in_range = ({1'b0, ram_wr_addr} < DEPTH_L);
        rd_in_range = ({1'b0, ram_rd_addr} < DEPTH_L);
    end

    // Storage and registered read port; read-before-write on address collision.
    always_ff @(posedge clk) begin
        if (ram_wr_en && wr_in_range) begin
            mem_array[ram_wr_addr] <= ram_wr_data;
        end
        if (ram_rd_en && rd_in_range) begin
            ram_q_reg <= mem_array[ram_rd_addr];
        end
    end

    // Out-of-range flag and functional request tag that travel with the array read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            range_q_reg <= 1'b0;
            v0_reg      <= 1'b0;
        end else begin
            if (ram_rd_en) begin
                range_q_reg <= rd_in_range;
            end
            v0_reg <= mem_rd_en && !bist_busy;
        end
    end

    assign ram_q = range_q_reg ? ram_q_reg : '0;

    generate
        if (LAT == 1) begin : g_lat1
            assign last_data  = ram_q;
            assign last_valid = v0_reg;
        end else begin : g_lat2
            logic [DATA_W-1:0] d1_reg;
            logic              v1_reg;

            // Extra pipeline stage for two-cycle read latency.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    d1_reg <= '0;
                    v1_reg <= 1'b0;
                end else begin
                    d1_reg <= ram_q;
                    v1_reg <= v0_reg && !bist_busy;
                end
            end

            assign last_data  = d1_reg;
            assign last_valid = v1_reg;
        end
    endgenerate

    // Output register: loads only on a functional completion, holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= last_valid && !bist_busy;
            if (last_valid && !bist_busy) begin
                rd_data_reg <= last_data;
            end
        end
    end

    assign mem_rd_data  = rd_data_reg;
    assign mem_rd_valid = rd_valid_reg && !bist_busy;

endmodule

// File: tb/tb_mem_ram_2p_bist.sv
// Scoreboard bench: instance A at defaults (64x8, RD_LAT=2), instance B with
// DEPTH=5, RD_LAT=1, DATA_W=16. Reads push expected data/arrival cycle into a
// queue; per-instance monitors pop and compare whenever mem_rd_valid is seen.
module tb_mem_ram_2p_bist;

    typedef struct {
        logic [63:0] data;
        int          at;
        int          tag;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Instance A signals
    logic        a_wr_en = 1'b0, a_rd_en = 1'b0, a_bist_start = 1'b0;
    logic [2:0]  a_wr_addr = '0, a_rd_addr = '0;
    logic [63:0] a_wr_data = '0;
    logic [63:0] a_rd_data;
    logic        a_rd_valid, a_busy, a_done, a_fail;
    logic [2:0]  a_fail_addr;

    // Instance B signals
    logic        b_wr_en = 1'b0, b_rd_en = 1'b0, b_bist_start = 1'b0;
    logic [2:0]  b_wr_addr = '0, b_rd_addr = '0;
    logic [15:0] b_wr_data = '0;
    logic [15:0] b_rd_data;
    logic        b_rd_valid, b_busy, b_done, b_fail;
    logic [2:0]  b_fail_addr;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    mem_ram_2p_bist u_dut (
        .clk            (clk),
        .rst            (rst),
        .mem_wr_en      (a_wr_en),
        .mem_wr_addr    (a_wr_addr),
        .mem_wr_data    (a_wr_data),
        .mem_rd_en      (a_rd_en),
        .mem_rd_addr    (a_rd_addr),
        .mem_rd_data    (a_rd_data),
        .mem_rd_valid   (a_rd_valid),
        .bist_start     (a_bist_start),
        .bist_busy      (a_busy),
        .bist_done      (a_done),
        .bist_fail      (a_fail),
        .bist_fail_addr (a_fail_addr)
    );

    mem_ram_2p_bist #(.DATA_W(16), .DEPTH(5), .RD_LAT(1)) u_dut_b (
        .clk            (clk),
        .rst            (rst),
        .mem_wr_en      (b_wr_en),
        .mem_wr_addr    (b_wr_addr),
        .mem_wr_data    (b_wr_data),
        .mem_rd_en      (b_rd_en),
        .mem_rd_addr    (b_rd_addr),
        .mem_rd_data    (b_rd_data),
        .mem_rd_valid   (b_rd_valid),
        .bist_start     (b_bist_start),
        .bist_busy      (b_busy),
        .bist_done      (b_done),
        .bist_fail      (b_fail),
        .bist_fail_addr (b_fail_addr)
    );

    // Monitor A: every valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && a_rd_valid) begin
            total++;
            if (q_a.size() == 0) begin
                bad++;
                $display("FAIL rdA_unexpected: got data=%h at cyc=%0d, required no valid", a_rd_data, cyc);
            end else begin
                e_a = q_a.pop_front();
                if (a_rd_data !== e_a.data || cyc != e_a.at) begin
                    bad++;
                    $display("FAIL rdA_%0d: got data=%h cyc=%0d, required data=%h cyc=%0d",
                             e_a.tag, a_rd_data, cyc, e_a.data, e_a.at);
                end else begin
                    $display("rdA_%0d ok: data=%h cyc=%0d", e_a.tag, a_rd_data, cyc);
                end
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (!rst && b_rd_valid) begin
            total++;
            if (q_b.size() == 0) begin
                bad++;
                $display("FAIL rdB_unexpected: got data=%h at cyc=%0d, required no valid", b_rd_data, cyc);
            end else begin
                e_b = q_b.pop_front();
                if ({48'b0, b_rd_data} !== e_b.data || cyc != e_b.at) begin
                    bad++;
                    $display("FAIL rdB_%0d: got data=%h cyc=%0d, required data=%h cyc=%0d",
                             e_b.tag, b_rd_data, cyc, e_b.data[15:0], e_b.at);
                end else begin
                    $display("rdB_%0d ok: data=%h cyc=%0d", e_b.tag, b_rd_data, cyc);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end else begin
            $display("%s ok: %h", nm, act);
        end
    endtask

    task automatic op_a(input logic we, input logic [2:0] wa, input logic [63:0] wd,
                        input logic re, input logic [2:0] ra, input logic [63:0] ed, input int tag);
        @(negedge clk);
        a_wr_en = we; a_wr_addr = wa; a_wr_data = wd;
        a_rd_en = re; a_rd_addr = ra;
        if (re) q_a.push_back('{data: ed, at: cyc + 3, tag: tag});
    endtask

    task automatic op_b(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                        input logic re, input logic [2:0] ra, input logic [15:0] ed, input int tag);
        @(negedge clk);
        b_wr_en = we; b_wr_addr = wa; b_wr_data = wd;
        b_rd_en = re; b_rd_addr = ra;
        if (re) q_b.push_back('{data: {48'b0, ed}, at: cyc + 2, tag: tag});
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        a_wr_en = 1'b0; a_rd_en = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // mode 0: clean run with functional noise and a stray start while busy
    // mode 1: word 5 reads back with bit 7 stuck high during R0W1
    // mode 2: reset asserted 30 cycles into the run
    // mode 3: clean quiet run
    task automatic run_bist(input int mode, output int lat);
        int k;
        @(negedge clk);
        a_bist_start = 1'b1;
        k = cyc;
        @(negedge clk);
        a_bist_start = 1'b0;
        check("busy_rise", {63'b0, a_busy}, 64'd1);
        check("done_clear", {63'b0, a_done}, 64'd0);
        lat = -1;
        for (int i = 0; i < 300; i++) begin
            if (a_done) begin
                lat = cyc - k - 1;
                break;
            end
            if (mode == 2 && cyc == k + 31) begin
                rst = 1'b1;
                break;
            end
            a_rd_en      = (mode == 0 && cyc == k + 30);
            a_rd_addr    = 3'd3;
            a_wr_en      = (mode == 0 && cyc == k + 75);
            a_wr_addr    = 3'd0;
            a_wr_data    = '1;
            a_bist_start = (mode == 0 && cyc == k + 40);
            if (mode == 1 && cyc == k + 25) force u_dut.ram_q_reg = 64'h80;
            if (mode == 1 && cyc == k + 27) release u_dut.ram_q_reg;
            @(negedge clk);
        end
        a_rd_en = 1'b0; a_wr_en = 1'b0; a_bist_start = 1'b0;
    endtask

    initial begin
        int lat;
        repeat (2) @(negedge clk);
        check("rst_rd_data", a_rd_data, 64'd0);
        check("rst_rd_valid", {63'b0, a_rd_valid}, 64'd0);
        check("rst_busy", {63'b0, a_busy}, 64'd0);
        check("rst_done", {63'b0, a_done}, 64'd0);
        check("rst_fail", {63'b0, a_fail}, 64'd0);
        check("rst_fail_addr", {61'b0, a_fail_addr}, 64'd0);
        check("rst_b_rd_data", {48'b0, b_rd_data}, 64'd0);
        rst = 1'b0;

        // Basic write then read, two-cycle latency
        op_a(1'b1, 3'd3, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0, 3'd0, 64'd0, 0);
        op_a(1'b0, 3'd0, 64'd0, 1'b1, 3'd3, 64'hA5A5_A5A5_A5A5_A5A5, 1);
        idle(4);

        // Same-cycle read/write collision returns old data
        op_a(1'b1, 3'd2, 64'h11, 1'b0, 3'd0, 64'd0, 0);
        op_a(1'b1, 3'd2, 64'h22, 1'b1, 3'd2, 64'h11, 2);
        op_a(1'b0, 3'd0, 64'd0, 1'b1, 3'd2, 64'h22, 3);
        idle(4);
        check("rd_hold_data", a_rd_data, 64'h22);
        check("rd_hold_valid", {63'b0, a_rd_valid}, 64'd0);

        // Instance B: back-to-back reads, out-of-range read and dropped write
        for (int i = 0; i < 5; i++) op_b(1'b1, 3'(i), 16'(16'h100 + i), 1'b0, 3'd0, 16'd0, 0);
        for (int i = 0; i < 5; i++) op_b(1'b0, 3'd0, 16'd0, 1'b1, 3'(i), 16'(16'h100 + i), 10 + i);
        op_b(1'b0, 3'd0, 16'd0, 1'b1, 3'd6, 16'd0, 20);
        op_b(1'b1, 3'd6, 16'hDEAD, 1'b0, 3'd0, 16'd0, 0);
        for (int i = 0; i < 5; i++) op_b(1'b0, 3'd0, 16'd0, 1'b1, 3'(i), 16'(16'h100 + i), 30 + i);
        idle(4);

        // Clean BIST with functional traffic ignored while busy
        run_bist(0, lat);
        check("bist0_latency", 64'(lat), 64'd80);
        check("bist0_done", {63'b0, a_done}, 64'd1);
        check("bist0_busy", {63'b0, a_busy}, 64'd0);
        check("bist0_fail", {63'b0, a_fail}, 64'd0);
        op_a(1'b0, 3'd0, 64'd0, 1'b1, 3'd0, 64'd0, 40);
        op_a(1'b0, 3'd0, 64'd0, 1'b1, 3'd3, 64'd0, 41);
        idle(4);

        // Stuck bit on word 5
        run_bist(1, lat);
        check("bist1_latency", 64'(lat), 64'd80);
        check("bist1_done", {63'b0, a_done}, 64'd1);
        check("bist1_fail", {63'b0, a_fail}, 64'd1);
        check("bist1_fail_addr", {61'b0, a_fail_addr}, 64'd5);

        // Reset mid-run, then a fresh clean run
        run_bist(2, lat);
        @(negedge clk);
        check("abort_busy", {63'b0, a_busy}, 64'd0);
        check("abort_done", {63'b0, a_done}, 64'd0);
        check("abort_fail", {63'b0, a_fail}, 64'd0);
        check("abort_fail_addr", {61'b0, a_fail_addr}, 64'd0);
        rst = 1'b0;
        run_bist(3, lat);
        check("bist3_latency", 64'(lat), 64'd80);
        check("bist3_done", {63'b0, a_done}, 64'd1);
        check("bist3_fail", {63'b0, a_fail}, 64'd0);

        idle(2);
        check("qA_drained", 64'(q_a.size()), 64'd0);
        check("qB_drained", 64'(q_b.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
